// File: rtl/rtc_read_sequencer.sv
// rtl/rtc_read_sequencer.sv - RTC register burst reader driving a multiplexed address/data bus
module rtc_read_sequencer #(
  parameter int         N_READS = 11,
  parameter logic [7:0] T_LAST  = 8'h2F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] data_vga,
  output logic [7:0] contador,
  output logic       Read,
  output logic       IndicadorMaquina,
  output logic [7:0] address,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam int             IW       = (N_READS > 1) ? $clog2(N_READS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_READS - 1);
  localparam logic [7:0]     ADDR_TBL [0:10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                                 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

  state_t        state, state_nxt;
  logic [7:0]    cont_nxt, addr_nxt;
  logic [IW-1:0] index, index_nxt, idx_inc;

  logic [7:0] ad_out_d;
  logic       ad_oe_d, cs_n_d, rd_n_d, wr_n_d, a_d_d, read_d;
  logic       xfer_nxt, wr_ph, rd_ph;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      contador <= 8'h00;
      index    <= '0;
      address  <= 8'h00;
    end else begin
      state    <= state_nxt;
      contador <= cont_nxt;
      index    <= index_nxt;
      address  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cont_nxt  = contador;
    index_nxt = index;
    addr_nxt  = address;
    idx_inc   = index + 1'b1;
    case (state)
      IDLE: begin
        cont_nxt = 8'h00;
        if (start) begin
          state_nxt = XFER;
          index_nxt = '0;
          addr_nxt  = ADDR_TBL[0];
        end
      end
      XFER: begin
        if (contador == T_LAST) begin
          cont_nxt = 8'h00;
          if (index == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            index_nxt = idx_inc;
            addr_nxt  = ADDR_TBL[idx_inc];
          end
        end else begin
          cont_nxt = contador + 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cont_nxt  = 8'h00;
      end
      default: begin
        state_nxt = IDLE;
        cont_nxt  = 8'h00;
      end
    endcase
  end

  // Bus phases decode the upcoming counter value so the registered strobes
  // change on the same edge that contador enters each range.
  always_comb begin
    xfer_nxt = (state_nxt == XFER);
    wr_ph    = xfer_nxt && (cont_nxt >= 8'h04) && (cont_nxt <= 8'h0B);
    rd_ph    = xfer_nxt && (cont_nxt >= 8'h12) && (cont_nxt <= 8'h1F);
    cs_n_d   = !(wr_ph || rd_ph);
    wr_n_d   = !wr_ph;
    rd_n_d   = !rd_ph;
    a_d_d    = !wr_ph;
    ad_oe_d  = wr_ph;
    ad_out_d = wr_ph ? addr_nxt : 8'h00;
    read_d   = xfer_nxt && (cont_nxt >= 8'h12) && (cont_nxt <= 8'h26);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      a_d      <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= 8'h00;
      Read     <= 1'b0;
      data_vga <= 8'h00;
    end else begin
      cs_n   <= cs_n_d;
      rd_n   <= rd_n_d;
      wr_n   <= wr_n_d;
      a_d    <= a_d_d;
      ad_oe  <= ad_oe_d;
      ad_out <= ad_out_d;
      Read   <= read_d;
      if (state == XFER && contador == 8'h16)
        data_vga <= ad_in;
    end
  end

  assign IndicadorMaquina = (state == XFER);
  assign done             = (state == DONE);

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb/tb_rtc_read_sequencer.sv - randomized self-checking bench for rtc_read_sequencer
module tb_rtc_read_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ad_in = 8'h00;
  logic [7:0] ad_out, data_vga, contador, address;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, Read, IndicadorMaquina, done;

  int total = 0;
  int bad   = 0;

  rtc_read_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .data_vga(data_vga), .contador(contador), .Read(Read),
    .IndicadorMaquina(IndicadorMaquina), .address(address), .done(done)
  );

  always #5 clk = ~clk;

  logic [39:0] outs;
  assign outs = {cs_n, rd_n, wr_n, a_d, ad_oe, Read, IndicadorMaquina, done,
                 contador, address, ad_out, data_vga};

  localparam logic [39:0] RESET_OUTS = {8'b1111_0000, 32'h0};

  // RTC model: latches the address seen in the write phase, answers with
  // address+0x10 while rd_n is low, and drives noise otherwise.
  logic [7:0] rtc_lat = 8'h00;
  always @(negedge clk) begin
    if (ad_oe) rtc_lat = ad_out;
    ad_in = rd_n ? 8'($urandom) : rtc_lat + 8'h10;
  end

  function automatic logic [7:0] tbl_addr(input int t);
    return (t < 8) ? 8'(8'h21 + t) : 8'(8'h41 + (t - 8));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    step();
    step();
    total++;
    if (outs !== RESET_OUTS) begin
      bad++;
      $display("FAIL reset_with_start got=%h exp=%h", outs, RESET_OUTS);
    end
    start = 1'b0;
    reset = 1'b0;
    step();
    total++;
    if (outs !== RESET_OUTS) begin
      bad++;
      $display("FAIL idle_after_reset got=%h exp=%h", outs, RESET_OUTS);
    end
  endtask

  task automatic test_full_burst(input logic [7:0] init_data, input bit poke_start);
    logic [7:0]  exp_data;
    logic [39:0] exp;
    int          idle_cycles;
    exp_data    = init_data;
    idle_cycles = $urandom_range(0, 5);
    for (int i = 0; i < idle_cycles; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 529; k++) begin
      if (k > 0) begin
        start = (poke_start && k <= 527) ? 1'($urandom) : 1'b0;
        step();
      end
      if (k < 528) begin
        int t, c;
        logic [7:0] a;
        bit wph, rph, rdw;
        t   = k / 48;
        c   = k % 48;
        a   = tbl_addr(t);
        wph = (c >= 4) && (c <= 11);
        rph = (c >= 18) && (c <= 31);
        rdw = (c >= 18) && (c <= 38);
        if (c == 8'h17) exp_data = a + 8'h10;
        exp = {~(wph | rph), ~rph, ~wph, ~wph, wph, rdw, 1'b1, 1'b0,
               8'(c), a, (wph ? a : 8'h00), exp_data};
      end else begin
        exp = {4'b1111, 1'b0, 1'b0, 1'b0, (k == 528), 8'h00, 8'h43, 8'h00, exp_data};
      end
      total++;
      if (outs !== exp) begin
        bad++;
        $display("FAIL burst k=%0d got=%h exp=%h", k, outs, exp);
      end
      total++;
      if (ad_oe === 1'b1 && rd_n === 1'b0) begin
        bad++;
        $display("FAIL bus_contention k=%0d got ad_oe=1 rd_n=0 exp no overlap", k);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_start_held();
    int done_cnt, done_edge;
    do_reset();
    done_cnt  = 0;
    done_edge = -1;
    start = 1'b1;
    step();
    for (int k = 1; k <= 529; k++) begin
      step();
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
    end
    total++;
    if (done_cnt != 1 || done_edge != 528) begin
      bad++;
      $display("FAIL start_held_done got count=%0d edge=%0d exp count=1 edge=528", done_cnt, done_edge);
    end
    step();
    total++;
    if (IndicadorMaquina !== 1'b1 || contador !== 8'h00 || address !== 8'h21) begin
      bad++;
      $display("FAIL start_held_restart got ind=%b cont=%h addr=%h exp ind=1 cont=00 addr=21",
               IndicadorMaquina, contador, address);
    end
    start = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4 * 48 + 8'h15; k++) step();
    total++;
    if (contador !== 8'h15 || address !== 8'h25) begin
      bad++;
      $display("FAIL midburst_position got cont=%h addr=%h exp cont=15 addr=25", contador, address);
    end
    reset = 1'b1;
    step();
    total++;
    if (outs !== RESET_OUTS) begin
      bad++;
      $display("FAIL midburst_reset got=%h exp=%h", outs, RESET_OUTS);
    end
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (IndicadorMaquina !== 1'b1 || contador !== 8'h00 || address !== 8'h21) begin
      bad++;
      $display("FAIL midburst_restart got ind=%b cont=%h addr=%h exp ind=1 cont=00 addr=21",
               IndicadorMaquina, contador, address);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_burst(8'h00, 1'b0);
    test_full_burst(8'h53, 1'b1);
    test_start_held();
    test_reset_midburst();
    do_reset();
    test_full_burst(8'h00, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
